// File: rtl/bayer_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bayer_frame_streamer
// Brief    : RGB pixel stream to single-channel Bayer raw stream with frame
//            start pulse, pre-frame gap, horizontal blanking and flush rows.
//            Define BAYER_STREAMER_TESTPAT_EN to add the iTestPat generator.
// Revision : 1.0 - initial release
// ============================================================================
module bayer_frame_streamer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int H_BLANK    = 16,
    parameter int PRE_FRAME  = 32,
    parameter int FLUSH_ROWS = 3,
    parameter int PIXEL_BITS = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 iStart,
    input  logic [1:0]                           iBayerMode,
`ifdef BAYER_STREAMER_TESTPAT_EN
    input  logic                                 iTestPat,
`endif
    input  logic                                 iValid,
    output logic                                 iReady,
    input  logic [PIXEL_BITS-1:0]                iR,
    input  logic [PIXEL_BITS-1:0]                iG,
    input  logic [PIXEL_BITS-1:0]                iB,
    output logic                                 oNewFrame,
    output logic                                 oValid,
    output logic [PIXEL_BITS-1:0]                oData,
    output logic [$clog2(HEIGHT+FLUSH_ROWS)-1:0] oRow,
    output logic [$clog2(WIDTH)-1:0]             oCol,
    output logic                                 oBusy,
    output logic                                 oDone
);
    localparam int ROW_W   = $clog2(HEIGHT + FLUSH_ROWS);
    localparam int ROWC_W  = ROW_W + 1;
    localparam int COL_W   = $clog2(WIDTH);
    localparam int CNT_MAX = (PRE_FRAME > H_BLANK) ? PRE_FRAME : H_BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_pre    = 3'd1;
    localparam logic [2:0] c_st_active = 3'd2;
    localparam logic [2:0] c_st_hblank = 3'd3;
    localparam logic [2:0] c_st_flush  = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    localparam logic [ROWC_W-1:0] c_height     = ROWC_W'(HEIGHT);
    localparam logic [ROWC_W-1:0] c_rows_total = ROWC_W'(HEIGHT + FLUSH_ROWS);
    localparam logic [COL_W-1:0]  c_col_last   = COL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_pre_last   = CNT_W'(PRE_FRAME - 1);
    localparam logic [CNT_W-1:0]  c_hb_last    = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic              c_has_hblank = (H_BLANK > 0);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [1:0]            r_mode;
    logic [ROWC_W-1:0]     r_row;
    logic [COL_W-1:0]      r_col;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_new_frame;
    logic                  r_valid;
    logic [PIXEL_BITS-1:0] r_data;
    logic [ROW_W-1:0]      r_out_row;
    logic [COL_W-1:0]      r_out_col;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start;
    logic                  w_ready;
    logic                  w_adv;
    logic                  w_col_last;
    logic [ROWC_W-1:0]     w_row_inc;
    logic [PIXEL_BITS-1:0] w_cfa;
    logic [PIXEL_BITS-1:0] w_pat;
    logic [PIXEL_BITS-1:0] w_sample;
    logic                  w_test_pat;

    // Where a finished row (row index already advanced) leads next.
    function automatic logic [2:0] f_row_exit(input logic [ROWC_W-1:0] row_n);
        if (row_n < c_height)
            f_row_exit = c_st_active;
        else if (row_n < c_rows_total)
            f_row_exit = c_st_flush;
        else
            f_row_exit = c_st_done;
    endfunction

`ifdef BAYER_STREAMER_TESTPAT_EN
    logic r_test_pat;

    always_ff @(posedge clk) begin
        if (!reset)
            r_test_pat <= 1'b0;
        else if (w_start)
            r_test_pat <= iTestPat;
    end

    assign w_test_pat = r_test_pat;
    assign w_pat      = PIXEL_BITS'(32'(r_row) + 32'(r_col));
`else
    assign w_test_pat = 1'b0;
    assign w_pat      = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (iStart) w_state_next = c_st_pre;
            c_st_pre:    if (r_cnt == c_pre_last) w_state_next = c_st_active;
            c_st_active,
            c_st_flush:  if (w_adv && w_col_last)
                             w_state_next = c_has_hblank ? c_st_hblank : f_row_exit(w_row_inc);
            c_st_hblank: if (r_cnt == c_hb_last) w_state_next = f_row_exit(r_row);
            c_st_done:   w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_start    = (r_state == c_st_idle) && iStart;
        w_ready    = (r_state == c_st_active) && !w_test_pat;
        w_adv      = ((r_state == c_st_active) && (w_test_pat || iValid)) ||
                     (r_state == c_st_flush);
        w_col_last = (r_col == c_col_last);
        w_row_inc  = r_row + ROWC_W'(1);
        if (r_state == c_st_flush)
            w_sample = '0;
        else if (w_test_pat)
            w_sample = w_pat;
        else
            w_sample = w_cfa;
    end

    // CFA pick keyed on {mode, row parity, column parity}; green is the default.
    always_comb begin
        w_cfa = iG;
        case ({r_mode, r_row[0], r_col[0]})
            4'b0001, 4'b0110, 4'b1011, 4'b1100: w_cfa = iB;
            4'b0010, 4'b0101, 4'b1000, 4'b1111: w_cfa = iR;
            default:                            w_cfa = iG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode      <= 2'd0;
            r_row       <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_new_frame <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_new_frame <= w_start;
            r_done      <= (r_state == c_st_done);
            r_valid     <= w_adv;
            if (w_start)
                r_busy <= 1'b1;
            else if (r_done)
                r_busy <= 1'b0;

            if (w_start) begin
                r_mode <= iBayerMode;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_adv) begin
                r_data    <= w_sample;
                r_out_row <= r_row[ROW_W-1:0];
                r_out_col <= r_col;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_inc;
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end

            // Counter restarts on every state change; only PRE and HBLANK look at it.
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if ((r_state == c_st_pre) || (r_state == c_st_hblank))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign iReady    = w_ready;
    assign oNewFrame = r_new_frame;
    assign oValid    = r_valid;
    assign oData     = r_data;
    assign oRow      = r_out_row;
    assign oCol      = r_out_col;
    assign oBusy     = r_busy;
    assign oDone     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bayer_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bayer_frame_streamer
// Brief    : Scoreboard bench for bayer_frame_streamer (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bayer_frame_streamer;
    // Instance A: W4 H2 hBlank2 preFrame3 flush1. Instance B: W4 H2 hBlank0 preFrame1 flush0.
    localparam int A_NF_GAP   = 4;
    localparam int A_ROW_GAP  = 3;
    localparam int A_DONE_GAP = 3;
    localparam int B_NF_GAP   = 2;
    localparam int B_ROW_GAP  = 1;
    localparam int B_DONE_GAP = 1;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int c_ramp [8]     = '{32, 49, 34, 51, 20, 37, 22, 39};
    int c_const [4][8] = '{'{20, 30, 20, 30, 10, 20, 10, 20},
                           '{20, 10, 20, 10, 30, 20, 30, 20},
                           '{10, 20, 10, 20, 20, 30, 20, 30},
                           '{30, 20, 30, 20, 20, 10, 20, 10}};

    logic       a_start, a_valid, a_ready, a_nf, a_ov, a_busy, a_done;
    logic [1:0] a_mode;
    logic [7:0] a_r, a_g, a_b, a_data;
    logic [1:0] a_row, a_col;
`ifdef BAYER_STREAMER_TESTPAT_EN
    logic       a_tp = 1'b0;
    int         c_pat [8] = '{0, 1, 2, 3, 1, 2, 3, 4};
`endif

    logic       b_start, b_valid, b_ready, b_nf, b_ov, b_busy, b_done;
    logic [1:0] b_mode;
    logic [7:0] b_r, b_g, b_b, b_data;
    logic [0:0] b_row;
    logic [1:0] b_col;

    bayer_frame_streamer #(
        .WIDTH(4), .HEIGHT(2), .H_BLANK(2), .PRE_FRAME(3), .FLUSH_ROWS(1), .PIXEL_BITS(8)
    ) dut_a (
        .clk(clk), .reset(reset), .iStart(a_start), .iBayerMode(a_mode),
`ifdef BAYER_STREAMER_TESTPAT_EN
        .iTestPat(a_tp),
`endif
        .iValid(a_valid), .iReady(a_ready), .iR(a_r), .iG(a_g), .iB(a_b),
        .oNewFrame(a_nf), .oValid(a_ov), .oData(a_data), .oRow(a_row), .oCol(a_col),
        .oBusy(a_busy), .oDone(a_done)
    );

    bayer_frame_streamer #(
        .WIDTH(4), .HEIGHT(2), .H_BLANK(0), .PRE_FRAME(1), .FLUSH_ROWS(0), .PIXEL_BITS(8)
    ) dut_b (
        .clk(clk), .reset(reset), .iStart(b_start), .iBayerMode(b_mode),
`ifdef BAYER_STREAMER_TESTPAT_EN
        .iTestPat(1'b0),
`endif
        .iValid(b_valid), .iReady(b_ready), .iR(b_r), .iG(b_g), .iB(b_b),
        .oNewFrame(b_nf), .oValid(b_ov), .oData(b_data), .oRow(b_row), .oCol(b_col),
        .oBusy(b_busy), .oDone(b_done)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int a_nf_cnt = 0, a_done_cnt = 0, a_nf_cyc = 0, a_last = 0;
    int b_nf_cnt = 0, b_done_cnt = 0, b_nf_cyc = 0, b_last = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int d, input int r, input int c);
        exp_t e;
        e.d = 8'(d);
        e.r = 8'(r);
        e.c = 8'(c);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (a_nf) begin
                a_nf_cnt++;
                a_nf_cyc = cyc;
            end
            if (a_ov) begin
                if (qa.size() == 0) begin
                    chk("a_extra_sample", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_data", a_data, ea.d);
                    chk("a_row", a_row, ea.r);
                    chk("a_col", a_col, ea.c);
                    if (ea.r == 0 && ea.c == 0)
                        chk("a_preframe_gap", cyc - a_nf_cyc, A_NF_GAP);
                    else if (ea.c == 0)
                        chk("a_hblank_gap", cyc - a_last, A_ROW_GAP);
                    a_last = cyc;
                end
            end
            if (a_done) begin
                a_done_cnt++;
                chk("a_done_gap", cyc - a_last, A_DONE_GAP);
                chk("a_busy_at_done", a_busy, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (b_nf) begin
                b_nf_cnt++;
                b_nf_cyc = cyc;
            end
            if (b_ov) begin
                if (qb.size() == 0) begin
                    chk("b_extra_sample", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_data", b_data, eb.d);
                    chk("b_row", b_row, eb.r);
                    chk("b_col", b_col, eb.c);
                    if (eb.r == 0 && eb.c == 0)
                        chk("b_preframe_gap", cyc - b_nf_cyc, B_NF_GAP);
                    else if (eb.c == 0)
                        chk("b_row_gap", cyc - b_last, B_ROW_GAP);
                    b_last = cyc;
                end
            end
            if (b_done) begin
                b_done_cnt++;
                chk("b_done_gap", cyc - b_last, B_DONE_GAP);
                chk("b_busy_at_done", b_busy, 1);
            end
        end
    end

    task automatic start_a(input logic [1:0] m);
        a_mode  = m;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input exp_t e);
        int guard = 0;
        a_valid = 1'b1;
        a_r = r; a_g = g; a_b = b;
        while (!a_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_ready) chk("a_ready_timeout", 0, 1);
        else qa.push_back(e);
        @(negedge clk);
    endtask

    task automatic finish_a(input int n0);
        int guard = 0;
        a_valid = 1'b0;
        while (a_done_cnt == n0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("a_done_count", a_done_cnt, n0 + 1);
        chk("a_queue_drained", qa.size(), 0);
        qa.delete();
        @(negedge clk);
    endtask

    task automatic stall_a(input int hold_col);
        a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ovalid_low", a_ov, 0);
            chk("stall_ocol_hold", a_col, hold_col);
        end
    endtask

    task automatic frame_a_ramp(input int stall_at);
        int n0 = a_done_cnt;
        start_a(2'd0);
        for (int p = 0; p < 8; p++) begin
            if (p == stall_at) stall_a((p - 1) % 4);
            send_a(8'(16 + p), 8'(32 + p), 8'(48 + p), mk(c_ramp[p], p / 4, p % 4));
        end
        for (int c = 0; c < 4; c++) qa.push_back(mk(0, 2, c));
        finish_a(n0);
    endtask

    task automatic frame_a_const(input int m);
        int n0 = a_done_cnt;
        start_a(2'(m));
        for (int p = 0; p < 8; p++)
            send_a(8'd10, 8'd20, 8'd30, mk(c_const[m][p], p / 4, p % 4));
        for (int c = 0; c < 4; c++) qa.push_back(mk(0, 2, c));
        finish_a(n0);
    endtask

    task automatic send_b(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input exp_t e);
        int guard = 0;
        b_valid = 1'b1;
        b_r = r; b_g = g; b_b = b;
        while (!b_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!b_ready) chk("b_ready_timeout", 0, 1);
        else qb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int guard;
        a_start = 0; a_mode = 0; a_valid = 0; a_r = 0; a_g = 0; a_b = 0;
        b_start = 0; b_mode = 0; b_valid = 0; b_r = 0; b_g = 0; b_b = 0;
        repeat (3) @(negedge clk);
        chk("a_reset_outputs", int'({a_nf, a_ov, a_data, a_row, a_col, a_busy, a_done, a_ready}), 0);
        chk("b_reset_outputs", int'({b_nf, b_ov, b_data, b_row, b_col, b_busy, b_done, b_ready}), 0);
        reset = 1'b1;
        @(negedge clk);

        // Ramp frame in GBRG, then constant pixel in every CFA order.
        frame_a_ramp(-1);
        for (int m = 0; m < 4; m++) frame_a_const(m);

        // Five-cycle input stall mid-row.
        frame_a_ramp(2);

        // Reset during row 1, then a clean frame.
        n0 = a_done_cnt;
        start_a(2'd0);
        for (int p = 0; p < 5; p++)
            send_a(8'(16 + p), 8'(32 + p), 8'(48 + p), mk(c_ramp[p], p / 4, p % 4));
        a_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero", int'({a_nf, a_ov, a_data, a_row, a_col, a_busy, a_done, a_ready}), 0);
        chk("abort_queue_empty", qa.size(), 0);
        qa.delete();
        reset = 1'b1;
        @(negedge clk);
        frame_a_const(2);
        chk("abort_no_extra_done", a_done_cnt - n0, 1);

        // Back-to-back rows with no flush; iStart pulses while busy.
        n0 = b_done_cnt;
        b_mode  = 2'd0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (p == 2) b_start = 1'b1;
            if (p == 4) b_start = 1'b0;
            send_b(8'(16 + p), 8'(32 + p), 8'(48 + p), mk(c_ramp[p], p / 4, p % 4));
        end
        b_valid = 1'b0;
        guard = 0;
        while (b_done_cnt == n0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("b_done_count", b_done_cnt, n0 + 1);
        chk("b_queue_drained", qb.size(), 0);
        repeat (3) @(negedge clk);
        chk("b_busy_clear", b_busy, 0);
        chk("b_start_ignored", b_nf_cnt, 1);

`ifdef BAYER_STREAMER_TESTPAT_EN
        begin
            int ready_hits = 0;
            n0 = a_done_cnt;
            a_tp = 1'b1;
            start_a(2'd0);
            a_tp = 1'b0;
            for (int p = 0; p < 8; p++) qa.push_back(mk(c_pat[p], p / 4, p % 4));
            for (int c = 0; c < 4; c++) qa.push_back(mk(0, 2, c));
            guard = 0;
            while (a_done_cnt == n0 && guard < 100) begin
                @(negedge clk);
                if (a_ready) ready_hits++;
                guard++;
            end
            chk("tp_ready_low", ready_hits, 0);
            chk("tp_done_count", a_done_cnt, n0 + 1);
            chk("tp_queue_drained", qa.size(), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
